// File: rtl/cla_seq_divider_if.sv
// cla_seq_divider_if: valid/ready operand and result bundle
// between the CPU datapath and the sequential divider.
interface cla_seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/cla_seq_divider.sv
// cla_seq_divider: radix-2 restoring unsigned divider, one
// quotient bit per clock through a CLA trial subtractor.
module cla_seq_divider #(
    parameter int WIDTH   = 32,
    parameter int CLA_GRP = 4
) (
    input logic              clk,
    input logic              rst_n,
    cla_seq_divider_if.slave bus
);
    localparam int NG = WIDTH / CLA_GRP;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic [CW-1:0]    count;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             dbz_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;

    logic [WIDTH:0]   rs;
    logic [WIDTH-1:0] bn;
    logic [WIDTH-1:0] diff;
    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic             borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // Shifted partial remainder keeps the bit leaving R as bit WIDTH.
    assign rs = {r_reg, q_reg[WIDTH-1]};
    assign bn = ~d_reg;

    function automatic logic la_carry(
        input logic [CLA_GRP-1:0] g,
        input logic [CLA_GRP-1:0] p,
        input logic               ci,
        input int                 n
    );
        logic c;
        logic pr;
        c  = 1'b0;
        pr = 1'b1;
        for (int j = n - 1; j >= 0; j--) begin
            c  = c | (g[j] & pr);
            pr = pr & p[j];
        end
        return c | (pr & ci);
    endfunction

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        logic [CLA_GRP-1:0] g;
        logic [CLA_GRP-1:0] p;
        logic [CLA_GRP-1:0] s;

        assign g = rs[gi*CLA_GRP +: CLA_GRP] & bn[gi*CLA_GRP +: CLA_GRP];
        assign p = rs[gi*CLA_GRP +: CLA_GRP] ^ bn[gi*CLA_GRP +: CLA_GRP];

        always_comb begin
            s = '0;
            for (int k = 0; k < CLA_GRP; k++) begin
                s[k] = p[k] ^ la_carry(g, p, grp_c[gi], k);
            end
        end

        assign grp_g[gi] = la_carry(g, p, 1'b0, CLA_GRP);
        assign grp_p[gi] = &p;
        assign diff[gi*CLA_GRP +: CLA_GRP] = s;
    end

    // Carry-in of 1 completes the two's-complement subtract.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = 1'b1;
        for (int i = 0; i < NG; i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
    end

    assign borrow = ~(rs[WIDTH] ^ grp_c[NG]);
    assign r_next = borrow ? rs[WIDTH-1:0] : diff;
    assign q_next = {q_reg[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            d_reg       <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            count       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            dbz_r       <= 1'b0;
            quot_r      <= '0;
            rem_r       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        d_reg      <= bus.divisor;
                        q_reg      <= bus.dividend;
                        r_reg      <= '0;
                        count      <= '0;
                        in_ready_r <= 1'b0;
                        if (bus.divisor == '0) begin
                            state       <= DONE;
                            out_valid_r <= 1'b1;
                            dbz_r       <= 1'b1;
                            quot_r      <= '1;
                            rem_r       <= bus.dividend;
                        end else begin
                            state <= CALC;
                            dbz_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_next;
                    r_reg <= r_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        quot_r      <= q_next;
                        rem_r       <= r_next;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.quotient    = quot_r;
    assign bus.remainder   = rem_r;
endmodule

// File: tb/tb_cla_seq_divider.sv
// tb_cla_seq_divider: scoreboard bench for the sequential divider,
// directed corner cases followed by random operands with backpressure.
module tb_cla_seq_divider;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cla_seq_divider_if #(.WIDTH(W)) bus ();

    cla_seq_divider #(.WIDTH(W), .CLA_GRP(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    bit   rand_bp = 1'b0;
    exp_t mon_e;
    logic [63:0] mon_sum;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endfunction

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b);
        exp_t e;
        e.a = a;
        e.b = b;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 500) begin
            tick();
            guard++;
        end
        if (!bus.in_ready) begin
            n_total++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", bus.in_ready);
        end else begin
            bus.in_valid = 1'b1;
            bus.dividend = a;
            bus.divisor  = b;
            sb.push_back(model(a, b));
            tick();
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((sb.size() != 0 || !bus.in_ready) && g < 5000) begin
            tick();
            g++;
        end
        if (g >= 5000) begin
            n_total++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
        end
    endtask

    // Monitor: every accepted result is scored against the queue head.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL spurious_result: q=0x%0h r=0x%0h with no operation pending",
                         bus.quotient, bus.remainder);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", bus.quotient, mon_e.q);
                check("remainder", bus.remainder, mon_e.r);
                check("div_by_zero", bus.div_by_zero, mon_e.dz);
                if (mon_e.b != 0) begin
                    mon_sum = 64'(bus.quotient) * 64'(mon_e.b) + 64'(bus.remainder);
                    check("q_times_d_plus_r", mon_sum, 64'(mon_e.a));
                    check("rem_below_div", bus.remainder < mon_e.b, 1);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           n;
        exp_t         e4;
        logic [W-1:0] a;
        logic [W-1:0] b;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_quotient", bus.quotient, 0);
        check("reset_remainder", bus.remainder, 0);
        check("reset_div_by_zero", bus.div_by_zero, 0);
        rst_n = 1'b1;
        tick();
        check("reset_in_ready", bus.in_ready, 1);

        issue(32'd100, 32'd7);
        wait_valid(n);
        check("latency_100_7", n, W);
        wait_idle();

        issue(32'hFFFF_FFFF, 32'd1);
        issue(32'd5, 32'd9);
        issue(32'h0000_8FF0, 32'h0000_00F0);
        wait_idle();

        issue(32'h1234, 32'd0);
        check("dz_valid_next_cycle", bus.out_valid, 1);
        wait_idle();

        bus.out_ready = 1'b0;
        e4 = model(32'd5000, 32'd7);
        issue(32'd5000, 32'd7);
        wait_valid(n);
        check("latency_5000_7", n, W);
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.dividend = $urandom;
            bus.divisor  = $urandom | 32'd1;
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_quotient", bus.quotient, e4.q);
            check("bp_remainder", bus.remainder, e4.r);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_out_valid", bus.out_valid, 0);
        repeat (40) tick();

        issue(32'hDEAD_BEEF, 32'h0000_1357);
        repeat (17) tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        issue(32'd1000, 32'd10);
        wait_idle();

        rand_bp = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 31) == 0) b = '0;
            else b = $urandom >> $urandom_range(0, 31);
            issue(a, b);
        end
        wait_idle();
        rand_bp = 1'b0;
        tick();
        bus.out_ready = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
